command_dispatcher: RTL and testbench

Host-side issuer for the encrypt/decrypt/add/mult sequencer. It buffers host commands (opcode plus two operand base addresses) in a small FIFO. It drives the sequencer's configuration port with a one-cycle configuration pulse, then waits for the sequencer's completion flag. It retires each command with a one-cycle completion strobe to the host and sits between the host command bus and the sequencer.

---
 rtl/command_dispatcher.sv | 206 ++++++++++++++++++++
 tb/tb_command_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_dispatcher.sv
// ---------------------------------------------------------------------------
// command_dispatcher
//
// Host-side issuer for the encrypt/decrypt/add/mult sequencer. Host commands
// (opcode + two operand base addresses) are buffered in a small circular
// FIFO. The head command is presented to the sequencer with a one-cycle
// config_en pulse. The dispatcher then waits for the sequencer's done level
// and retires the command to the host with a one-cycle cmp_valid strobe. The
// head entry leaves the FIFO only at retire, so queue_count includes the
// command in flight.
//
// Optional feature macro: DISPATCH_TIMEOUT_EN
//   defined   : a WAIT watchdog retires a stuck command after TIMEOUT_CYCLES
//               WAIT cycles with cmp_error=1 (done on the same cycle wins)
//   undefined : WAIT lasts until done, cmp_error is constant 0
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   host command handshake (ready = FIFO not full)
//   cmd_opcode        00 encrypt, 01 decrypt, 10 add, 11 mult
//   cmd_op1/2_addr    operand base addresses from host
//   opcode, op1/op2_base_addr, config_en   registered sequencer config port
//   done              sequencer completion level
//   busy              FSM not idle or FIFO non-empty
//   cmp_valid/opcode/error  registered completion report to host
//   queue_count       FIFO occupancy
// ---------------------------------------------------------------------------
module command_dispatcher #(
  parameter int ADDR_WIDTH      = 8,
  parameter int QUEUE_DEPTH     = 4,
  parameter int QUEUE_PTR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_opcode,
  input  logic [ADDR_WIDTH-1:0]      cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0]      cmd_op2_addr,
  output logic [1:0]                 opcode,
  output logic                       config_en,
  output logic [ADDR_WIDTH-1:0]      op1_base_addr,
  output logic [ADDR_WIDTH-1:0]      op2_base_addr,
  input  logic                       done,
  output logic                       busy,
  output logic                       cmp_valid,
  output logic [1:0]                 cmp_opcode,
  output logic                       cmp_error,
  output logic [QUEUE_PTR_WIDTH:0]   queue_count
);

  localparam int ENTRY_W = 2 + 2 * ADDR_WIDTH;
  localparam int CNT_W   = QUEUE_PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;

  logic [ENTRY_W-1:0]         q_mem_r [QUEUE_DEPTH];
  logic [QUEUE_PTR_WIDTH-1:0] wr_ptr_r;
  logic [QUEUE_PTR_WIDTH-1:0] rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic [ENTRY_W-1:0]         head_s;

  logic                       push_s;
  logic                       issue_s;
  logic                       retire_s;
  logic                       timeout_s;
  logic                       wd_expired_s;

  assign cmd_ready   = (count_r != CNT_W'(QUEUE_DEPTH));
  assign push_s      = cmd_valid && cmd_ready;
  assign head_s      = q_mem_r[rd_ptr_r];
  assign queue_count = count_r;
  assign busy        = (state_r != ST_IDLE) || (count_r != CNT_W'(0));

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog: cleared during ISSUE (the only way into WAIT), counts WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= WD_W'(0);
    end else if (state_r == ST_ISSUE) begin
      wd_cnt_r <= WD_W'(0);
    end else if (state_r == ST_WAIT) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // The counter would reach TIMEOUT_CYCLES on this edge: this is the last
  // WAIT cycle, so a done seen in the same cycle still takes priority.
  assign wd_expired_s = (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^32'(TIMEOUT_CYCLES);
  assign wd_expired_s     = 1'b0;
`endif

  // FIFO storage, pointers and occupancy; the pop happens only at retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= QUEUE_PTR_WIDTH'(0);
      rd_ptr_r <= QUEUE_PTR_WIDTH'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_mem_r[i] <= ENTRY_W'(0);
      end
    end else begin
      if (push_s) begin
        q_mem_r[wr_ptr_r] <= {cmd_opcode, cmd_op1_addr, cmd_op2_addr};
        wr_ptr_r          <= wr_ptr_r + QUEUE_PTR_WIDTH'(1);
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + QUEUE_PTR_WIDTH'(1);
      end
      case ({push_s, retire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state plus issue/retire decisions. done is deliberately not
  // looked at in ISSUE: a stale done from the previous command may still be
  // high there, and the sequencer only clears it on the config_en edge.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    retire_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_W'(0)) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          retire_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wd_expired_s) begin
          retire_s    = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered sequencer configuration and host completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode        <= 2'b00;
      op1_base_addr <= ADDR_WIDTH'(0);
      op2_base_addr <= ADDR_WIDTH'(0);
      config_en     <= 1'b0;
      cmp_valid     <= 1'b0;
      cmp_opcode    <= 2'b00;
      cmp_error     <= 1'b0;
    end else begin
      config_en <= issue_s;
      cmp_valid <= retire_s;
      if (issue_s) begin
        {opcode, op1_base_addr, op2_base_addr} <= head_s;
      end
      if (retire_s) begin
        cmp_opcode <= opcode;
        cmp_error  <= timeout_s;
      end
    end
  end

endmodule

// File: tb/tb_command_dispatcher.sv
// Self-checking bench for command_dispatcher: a vector table of single
// commands plus hand-written sequences for queue-full, stale done, reset
// during WAIT and (with DISPATCH_TIMEOUT_EN) the watchdog. A monitor compares
// every config_en pulse and cmp_valid strobe against a scoreboard filled when
// the host handshake completes.
module tb_command_dispatcher;

  localparam int AW = 8;
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO   = 8;
  localparam int DLY1 = 5;
`else
  localparam int TO   = 1023;
  localparam int DLY1 = 12;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode;
  logic [AW-1:0] cmd_op1_addr;
  logic [AW-1:0] cmd_op2_addr;
  logic [1:0]    opcode;
  logic          config_en;
  logic [AW-1:0] op1_base_addr;
  logic [AW-1:0] op2_base_addr;
  logic          done;
  logic          busy;
  logic          cmp_valid;
  logic [1:0]    cmp_opcode;
  logic          cmp_error;
  logic [2:0]    queue_count;

  always #5 clk = ~clk;

  command_dispatcher #(
    .ADDR_WIDTH(AW), .QUEUE_DEPTH(4), .QUEUE_PTR_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1_addr(cmd_op1_addr),
    .cmd_op2_addr(cmd_op2_addr), .opcode(opcode), .config_en(config_en),
    .op1_base_addr(op1_base_addr), .op2_base_addr(op2_base_addr),
    .done(done), .busy(busy), .cmp_valid(cmp_valid), .cmp_opcode(cmp_opcode),
    .cmp_error(cmp_error), .queue_count(queue_count)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          err;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    int            dly;
    logic          exp_err;
    logic          exp_busy;
  } vec_t;

  exp_t issue_q[$];
  exp_t retire_q[$];
  vec_t vecs[5];

  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_cfg = 1'b0;
  logic prev_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic err);
    logic ok;
    logic got;
    exp_t e;
    got = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1_addr = a1; cmd_op2_addr = a2;
    for (int i = 0; i < 20 && !got; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) got = 1'b1;
    end
    cmd_valid = 1'b0;
    if (got) begin
      e.op = op; e.a1 = a1; e.a2 = a2; e.err = err;
      issue_q.push_back(e);
    end else begin
      bound_fail("push_accept");
    end
  endtask

  task automatic wait_cfg();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (config_en) seen = 1'b1;
      else tick();
    end
    if (!seen) bound_fail("wait_config_en");
  endtask

  task automatic wait_cmp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (cmp_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) bound_fail("wait_cmp_valid");
  endtask

  // Sequencer model: clear done on the config_en sampling edge, finish after dly.
  task automatic run_seq(input int dly);
    wait_cfg();
    tick();
    done = 1'b0;
    repeat (dly) tick();
    done = 1'b1;
    wait_cmp();
    tick();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (config_en) begin
          chk("config_en_width", 32'(prev_cfg), 32'd0);
          if (issue_q.size() == 0) begin
            bound_fail("config_en_unexpected");
          end else begin
            e = issue_q.pop_front();
            chk("issue_opcode", 32'(opcode), 32'(e.op));
            chk("issue_op1", 32'(op1_base_addr), 32'(e.a1));
            chk("issue_op2", 32'(op2_base_addr), 32'(e.a2));
            retire_q.push_back(e);
          end
        end
        if (cmp_valid) begin
          chk("cmp_valid_width", 32'(prev_cmp), 32'd0);
          if (retire_q.size() == 0) begin
            bound_fail("cmp_valid_unexpected");
          end else begin
            e = retire_q.pop_front();
            chk("cmp_opcode", 32'(cmp_opcode), 32'(e.op));
            chk("cmp_error", 32'(cmp_error), 32'(e.err));
          end
        end
      end
      prev_cfg = config_en;
      prev_cmp = cmp_valid;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_op1"}, 32'(op1_base_addr), 32'd0);
    chk({tag, "_op2"}, 32'(op2_base_addr), 32'd0);
    chk({tag, "_config_en"}, 32'(config_en), 32'd0);
    chk({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd0);
    chk({tag, "_cmp_opcode"}, 32'(cmp_opcode), 32'd0);
    chk({tag, "_cmp_error"}, 32'(cmp_error), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_queue_count"}, 32'(queue_count), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; done = 1'b0;
    cmd_opcode = 2'b00; cmd_op1_addr = 8'h00; cmd_op2_addr = 8'h00;
    vecs[0] = '{2'b10, 8'h10, 8'h20, DLY1, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 8'h00, 8'hFF, 0,    1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'hFF, 8'h00, 3,    1'b0, 1'b0};
    vecs[3] = '{2'b11, 8'hA5, 8'h5A, 1,    1'b0, 1'b0};
    vecs[4] = '{2'b10, 8'h7F, 8'h80, 6,    1'b0, 1'b0};
    fork
      monitor();
    join_none

    #12;
    chk_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Single commands from the vector table, with exact issue/retire latency.
    foreach (vecs[i]) begin
      push(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].exp_err);
      chk("cfg_before_e1", 32'(config_en), 32'd0);
      chk("busy_queued", 32'(busy), 32'd1);
      tick();
      chk("cfg_after_e1", 32'(config_en), 32'd1);
      tick();
      chk("cfg_one_cycle", 32'(config_en), 32'd0);
      done = 1'b0;
      for (int k = 0; k < vecs[i].dly; k++) begin
        chk("cmp_early", 32'(cmp_valid), 32'd0);
        tick();
      end
      done = 1'b1;
      tick();
      chk("cmp_after_done", 32'(cmp_valid), 32'd1);
      tick();
      chk("cmp_one_cycle", 32'(cmp_valid), 32'd0);
      chk("busy_after", 32'(busy), 32'(vecs[i].exp_busy));
      chk("opcode_hold", 32'(opcode), 32'(vecs[i].op));
    end

    // Fill the FIFO with done low; a fifth command waits for the first pop.
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(2'(i), 8'(8'h11 * i), 8'(8'hF0 - i), 1'b0);
    end
    chk("full_count", 32'(queue_count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_opcode = 2'b01; cmd_op1_addr = 8'hC3; cmd_op2_addr = 8'h3C;
    repeat (2) begin
      tick();
      chk("full_hold_count", 32'(queue_count), 32'd4);
    end
    done = 1'b1;
    tick();
    chk("first_retire", 32'(cmp_valid), 32'd1);
    chk("ready_after_pop", 32'(cmd_ready), 32'd1);
    chk("count_after_pop", 32'(queue_count), 32'd3);
    issue_q.push_back('{2'b01, 8'hC3, 8'h3C, 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("fifth_accepted", 32'(queue_count), 32'd4);
    chk("next_issue", 32'(config_en), 32'd1);
    tick();
    done = 1'b0;
    repeat (2) tick();
    done = 1'b1;
    wait_cmp();
    tick();
    repeat (3) run_seq(2);
    chk("drain_count", 32'(queue_count), 32'd0);
    chk("drain_issued", 32'(issue_q.size()), 32'd0);
    chk("drain_retired", 32'(retire_q.size()), 32'd0);

    // Stale done: still high from the last retire while the next command issues.
    push(2'b11, 8'h01, 8'h02, 1'b0);
    chk("stale_idle", 32'(cmp_valid), 32'd0);
    tick();
    chk("stale_cfg", 32'(config_en), 32'd1);
    chk("stale_issue", 32'(cmp_valid), 32'd0);
    tick();
    chk("stale_wait1", 32'(cmp_valid), 32'd0);
    done = 1'b0;
    repeat (3) begin
      tick();
      chk("stale_wait", 32'(cmp_valid), 32'd0);
    end
    done = 1'b1;
    tick();
    chk("stale_retire", 32'(cmp_valid), 32'd1);
    tick();

    // Asynchronous reset mid-WAIT with three entries queued.
    done = 1'b0;
    push(2'b11, 8'hAA, 8'h55, 1'b0);
    push(2'b01, 8'h0F, 8'hF0, 1'b0);
    push(2'b10, 8'h3C, 8'hC3, 1'b0);
    tick();
    chk("pre_reset_count", 32'(queue_count), 32'd3);
    chk("pre_reset_opcode", 32'(opcode), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    issue_q.delete();
    retire_q.delete();
    repeat (2) begin
      tick();
      chk("in_reset_cmp", 32'(cmp_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(busy), 32'd0);
    push(2'b01, 8'h33, 8'h44, 1'b0);
    run_seq(1);
    chk("recover_busy", 32'(busy), 32'd0);

`ifdef DISPATCH_TIMEOUT_EN
    // Watchdog expiry, then done on the last WAIT cycle beats the watchdog.
    push(2'b00, 8'h12, 8'h34, 1'b1);
    push(2'b10, 8'h56, 8'h78, 1'b0);
    chk("to_cfg", 32'(config_en), 32'd1);
    tick();
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_early", 32'(cmp_valid), 32'd0);
      tick();
    end
    chk("to_retire", 32'(cmp_valid), 32'd1);
    chk("to_error", 32'(cmp_error), 32'd1);
    tick();
    chk("to_next_issue", 32'(config_en), 32'd1);
    tick();
    repeat (7) tick();
    done = 1'b1;
    tick();
    chk("done_wins", 32'(cmp_valid), 32'd1);
    chk("done_wins_err", 32'(cmp_error), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
